// File: rtl/vga_pkg.sv
// Character code constants shared by the VGA text/font stages.
package vga_pkg;

  localparam int unsigned TXT_CW = 7;

  localparam logic [TXT_CW-1:0] SPACE = 7'h20;
  localparam logic [TXT_CW-1:0] CH_A  = 7'h41;
  localparam logic [TXT_CW-1:0] CH_E  = 7'h45;
  localparam logic [TXT_CW-1:0] CH_O  = 7'h4F;
  localparam logic [TXT_CW-1:0] CH_Z  = 7'h5A;
  // Custom glyph slots: left and right selection arrows.
  localparam logic [TXT_CW-1:0] NKL   = 7'h10;
  localparam logic [TXT_CW-1:0] NKR   = 7'h11;

endpackage

// File: rtl/game_text_buf_if.sv
// Bus between game logic / renderer and the on-screen text buffer.
interface game_text_buf_if
  import vga_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 16,
  parameter int unsigned CW   = TXT_CW
);

  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned CLW = $clog2(COLS);
  localparam int unsigned AW  = RW + CLW;

  logic          wr_en;
  logic [AW-1:0] wr_xy;
  logic [CW-1:0] wr_char;
  logic [AW-1:0] char_xy;
  logic [CW-1:0] char_code;
  logic          char_hl;
  logic          sel_up;
  logic          sel_down;
  logic [RW-1:0] sel_row;
  logic          ready;

  // Game control and renderer side.
  modport master (
    output wr_en, wr_xy, wr_char, char_xy, sel_up, sel_down,
    input  char_code, char_hl, sel_row, ready
  );

  // Text buffer side.
  modport slave (
    input  wr_en, wr_xy, wr_char, char_xy, sel_up, sel_down,
    output char_code, char_hl, sel_row, ready
  );

endinterface

// File: rtl/game_text_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// The array has no reset so it maps onto block/distributed RAM.
module game_text_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 7
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/game_text_buf.sv
// Writable ROWS x COLS character buffer with self-clear after reset, a
// registered read port for the renderer and a wrapping row-selection counter.
module game_text_buf
  import vga_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 16,
  parameter int unsigned CW   = TXT_CW
) (
  input  logic           clk_i,
  input  logic           rst_i,
  game_text_buf_if.slave bus_io
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CLW   = $clog2(COLS);
  localparam int unsigned AW    = RW + CLW;
  localparam int unsigned DEPTH = ROWS * COLS;

  localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] SpaceCode = CW'(SPACE);

  typedef enum logic {StClear, StIdle} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          ready_q;
  logic [RW-1:0] sel_q, sel_d;
  logic          rd_idle_q;
  logic          hl_q;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [CW-1:0] ram_wdata;
  logic [CW-1:0] ram_rdata;

  // Clear sequencer: sweep every address once, then hand over to normal use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == LastAddr) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        StIdle:  ;
        default: state_q <= StClear;
      endcase
    end
  end

  // Write mux: clear engine owns the port until the sweep is done.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = bus_io.wr_xy;
    ram_wdata = bus_io.wr_char;
    if (!rst_i) begin
      if (state_q == StClear) begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = SpaceCode;
      end else begin
        ram_we = bus_io.wr_en;
      end
    end
  end

  // Selection next state; row count is a power of two so wrap is free.
  always_comb begin
    sel_d = sel_q;
    if (state_q == StIdle) begin
      if (bus_io.sel_up && !bus_io.sel_down) begin
        sel_d = sel_q - RW'(1);
      end else if (bus_io.sel_down && !bus_io.sel_up) begin
        sel_d = sel_q + RW'(1);
      end
    end
  end

  // Selection register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Read-side flags, aligned with the RAM's registered output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_idle_q <= 1'b0;
      hl_q      <= 1'b0;
    end else begin
      rd_idle_q <= (state_q == StIdle);
      hl_q      <= (state_q == StIdle) && (bus_io.char_xy[AW-1:CLW] == sel_q);
    end
  end

  game_text_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus_io.char_xy),
    .rdata_o (ram_rdata)
  );

  // Reads sampled before the buffer is ready report blank cells.
  assign bus_io.char_code = rd_idle_q ? ram_rdata : SpaceCode;
  assign bus_io.char_hl   = hl_q;
  assign bus_io.sel_row   = sel_q;
  assign bus_io.ready     = ready_q;

endmodule
